mem_access_stage: RTL and testbench

Pipeline MEM stage: the consumer of the EX/MEM pipeline register (ALU result, store data, destination register, MemWrite/MemtoReg/RegWrite). It performs word loads and stores against a data memory over a req/ack handshake. It stalls upstream stages while an access is outstanding and presents registered MEM/WB outputs to writeback and to operand forwarding. Misaligned addresses and unanswered requests are killed and flagged.

---
 rtl/mem_access_stage_if.sv | 14 +
 rtl/mem_access_stage.sv | 131 +++++++++++++
 tb/tb_mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: word loads/stores over a req/ack bus, upstream stall while an access is
// outstanding, registered MEM/WB outputs, and kill-and-flag of misaligned or unanswered accesses.
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 16,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        towrite_in,
    input  logic              MemWrite_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    mem_access_stage_if.master dmem,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_towrite,
    output logic              wb_RegWrite,
    output logic              align_err,
    output logic              bus_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:2]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [4:0]          towrite_q;
    logic                regwrite_q;

    logic mem_op;
    logic misaligned;
    logic timeout_hit;

    assign mem_op      = valid_in & (MemWrite_in | MemtoReg_in);
    assign misaligned  = alu_result_in[1:0] != 2'b00;
    // Ack on the final allowed cycle still completes the access; only silence aborts.
    assign timeout_hit = (state_q == ACCESS) && !dmem.ack && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    assign dmem.req   = (state_q == ACCESS);
    assign dmem.we    = we_q;
    assign dmem.addr  = {addr_q, 2'b00};
    assign dmem.wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = !dmem.ack && !timeout_hit;
                if (dmem.ack || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture / completion stage: access registers and MEM/WB outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            towrite_q   <= '0;
            regwrite_q  <= 1'b0;
            wb_data     <= '0;
            wb_towrite  <= '0;
            wb_RegWrite <= 1'b0;
            align_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!mem_op) begin
                        wb_data     <= alu_result_in;
                        wb_towrite  <= towrite_in;
                        wb_RegWrite <= valid_in & RegWrite_in;
                    end else if (misaligned) begin
                        align_err   <= 1'b1;
                        wb_RegWrite <= 1'b0;
                    end else begin
                        addr_q      <= alu_result_in[DATA_W-1:2];
                        wdata_q     <= store_data_in;
                        we_q        <= MemWrite_in;
                        towrite_q   <= towrite_in;
                        regwrite_q  <= RegWrite_in;
                        cnt_q       <= '0;
                        wb_RegWrite <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem.ack) begin
                        if (!we_q) begin
                            wb_data     <= dmem.rdata;
                            wb_towrite  <= towrite_q;
                            wb_RegWrite <= regwrite_q;
                        end else begin
                            wb_RegWrite <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        bus_err     <= 1'b1;
                        wb_RegWrite <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: memory-slave model, request checker and
// writeback/error monitor, all fed by a high-level reference of loads, stores and ALU ops.
module tb_mem_access_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  towrite_in;
    logic        MemWrite_in, MemtoReg_in, RegWrite_in;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_towrite;
    logic        wb_RegWrite, align_err, bus_err;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(32)) dmem_bus ();

    mem_access_stage #(.ACK_TIMEOUT(T), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .towrite_in(towrite_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .dmem(dmem_bus), .stall(stall), .wb_data(wb_data),
        .wb_towrite(wb_towrite), .wb_RegWrite(wb_RegWrite),
        .align_err(align_err), .bus_err(bus_err)
    );

    // kind: 0 = register writeback, 1 = align_err, 2 = bus_err
    typedef struct { int kind; logic [31:0] data; logic [4:0] rd; } res_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int k; } req_t;

    res_t exp_q[$];
    req_t req_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] blank_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : blank_word(a);
    endfunction

    // Presents one instruction at a falling edge, records what it must produce, and
    // holds it until the stage accepts it. k = ack delay in ACCESS cycles (k >= T: never).
    task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic mw, input logic mr,
                         input logic rw, input int k);
        logic mem_op;
        int   exp_stall;
        int   stall_cnt;
        mem_op    = v & (mw | mr);
        exp_stall = 0;
        if (!mem_op) begin
            if (v && rw) exp_q.push_back('{kind: 0, data: alu, rd: rd});
        end else if (alu[1:0] != 2'b00) begin
            exp_q.push_back('{kind: 1, data: 32'h0, rd: 5'd0});
        end else begin
            req_q.push_back('{addr: alu, we: mw, wdata: sd, k: k});
            if (k < T) begin
                exp_stall = k + 1;
                if (mw) ref_mem[alu] = sd;
                else if (rw) exp_q.push_back('{kind: 0, data: ref_read(alu), rd: rd});
            end else begin
                exp_stall = T;
                exp_q.push_back('{kind: 2, data: 32'h0, rd: 5'd0});
            end
        end
        valid_in = v; alu_result_in = alu; store_data_in = sd; towrite_in = rd;
        MemWrite_in = mw; MemtoReg_in = mr; RegWrite_in = rw;
        stall_cnt = 0;
        #1;
        while (stall === 1'b1 && stall_cnt < 200) begin
            stall_cnt++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", stall_cnt, exp_stall);
        @(negedge clk);
    endtask

    // Data-memory slave: answers each request after its planned delay and checks the bus
    initial begin : slave
        req_t cur;
        bit   in_req;
        int   cyc;
        in_req = 0;
        cyc    = 0;
        cur    = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, k: 0};
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                in_req = 0;
                dmem_bus.ack = 1'b0;
            end else if (dmem_bus.req) begin
                if (!in_req) begin
                    in_req = 1;
                    cyc    = 0;
                    if (req_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: got addr %h expected no request", dmem_bus.addr);
                        cur = '{addr: dmem_bus.addr, we: dmem_bus.we, wdata: dmem_bus.wdata, k: 1000};
                    end else begin
                        cur = req_q.pop_front();
                    end
                end else begin
                    cyc++;
                end
                check("dmem_addr", dmem_bus.addr, cur.addr);
                check("dmem_we", 32'(dmem_bus.we), 32'(cur.we));
                if (cur.we) check("dmem_wdata", dmem_bus.wdata, cur.wdata);
                if (cyc == cur.k) begin
                    dmem_bus.ack = 1'b1;
                    if (cur.we) dev_mem[cur.addr] = cur.wdata;
                    else dmem_bus.rdata = dev_mem.exists(cur.addr) ? dev_mem[cur.addr]
                                                                    : blank_word(cur.addr);
                end else begin
                    dmem_bus.ack   = 1'b0;
                    dmem_bus.rdata = $urandom;
                end
            end else begin
                if (in_req) begin
                    check("req_cycles", cyc + 1, (cur.k < T) ? cur.k + 1 : T);
                    in_req = 0;
                end
                dmem_bus.ack   = ($urandom_range(3) == 0);
                dmem_bus.rdata = $urandom;
            end
        end
    end

    // Monitor: pops one expectation per visible writeback or error pulse
    initial begin : monitor
        res_t r;
        int   kind;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (wb_RegWrite === 1'b1 || align_err === 1'b1 || bus_err === 1'b1)) begin
                if (32'(wb_RegWrite) + 32'(align_err) + 32'(bus_err) > 1) begin
                    n_checks++; n_fail++;
                    $display("FAIL multi_output: got wb=%b align=%b bus=%b expected one",
                             wb_RegWrite, align_err, bus_err);
                end
                kind = wb_RegWrite ? 0 : (align_err ? 1 : 2);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got kind %0d expected none", kind);
                end else begin
                    r = exp_q.pop_front();
                    check("out_kind", kind, r.kind);
                    if (kind == 0 && r.kind == 0) begin
                        check("wb_data", wb_data, r.data);
                        check("wb_towrite", 32'(wb_towrite), 32'(r.rd));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(dmem_bus.req), 32'h0);
        check({tag, "_we"}, 32'(dmem_bus.we), 32'h0);
        check({tag, "_addr"}, dmem_bus.addr, 32'h0);
        check({tag, "_wdata"}, dmem_bus.wdata, 32'h0);
        check({tag, "_wb_data"}, wb_data, 32'h0);
        check({tag, "_wb_towrite"}, 32'(wb_towrite), 32'h0);
        check({tag, "_wb_RegWrite"}, 32'(wb_RegWrite), 32'h0);
        check({tag, "_align_err"}, 32'(align_err), 32'h0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    endtask

    initial begin : driver
        int          op;
        logic [31:0] a;
        reset = 1'b1;
        valid_in = 0; alu_result_in = 0; store_data_in = 0; towrite_in = 0;
        MemWrite_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
        @(negedge clk); @(negedge clk);
        check_all_zero("rst");
        check("rst_stall_idle", 32'(stall), 32'h0);
        valid_in = 1; MemtoReg_in = 1; alu_result_in = 32'h40;
        #1;
        check("rst_stall_memop", 32'(stall), 32'h1);
        valid_in = 0; MemtoReg_in = 0; alu_result_in = 0;
        @(negedge clk);
        reset = 1'b0;

        issue(1, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 1, 0);
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        dev_mem[32'h100] = 32'hDEAD_BEEF;
        issue(1, 32'h0000_0100, 32'h0, 5'd9, 0, 1, 1, 2);
        issue(1, 32'h0000_0200, 32'hCAFE_F00D, 5'd7, 1, 0, 0, 0);
        issue(1, 32'h0000_0102, 32'h0, 5'd3, 0, 1, 1, 0);
        issue(1, 32'h0000_0140, 32'h0, 5'd4, 0, 1, 1, T + 3);
        issue(1, 32'h0000_00AB, 32'h0, 5'd6, 0, 0, 1, 0);
        issue(1, 32'h0000_0200, 32'h0, 5'd8, 0, 1, 1, T - 1);
        issue(1, 32'h0000_0204, 32'h1111_2222, 5'd1, 1, 1, 1, 1);
        issue(1, 32'h0000_0204, 32'h0, 5'd2, 0, 1, 1, 0);
        issue(0, 32'h0000_0300, 32'h0, 5'd2, 1, 1, 1, 0);

        // Reset in the second ACCESS cycle of a load that never gets an answer
        req_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, k: 1000});
        valid_in = 1; alu_result_in = 32'h300; MemtoReg_in = 1; MemWrite_in = 0;
        RegWrite_in = 1; towrite_in = 5'd12;
        @(negedge clk); @(negedge clk);
        check("pre_rst_req", 32'(dmem_bus.req), 32'h1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        valid_in = 0;
        #1;
        check("midrst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) issue(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        issue(1, 32'h0000_0100, 32'h0, 5'd13, 0, 1, 1, 1);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'h1000 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
            case (op)
                0:       issue(0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
                1, 2, 3: issue(1, $urandom, $urandom, 5'($urandom), 0, 0, 1'($urandom), 0);
                4, 5, 6: issue(1, a, $urandom, 5'($urandom), 0, 1, ($urandom_range(0, 5) != 0),
                               $urandom_range(0, T + 1));
                default: issue(1, a, $urandom, 5'($urandom), 1, 1'($urandom), 1'($urandom),
                               $urandom_range(0, T + 1));
            endcase
        end

        for (int i = 0; i < 4; i++) issue(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        check("exp_queue_empty", exp_q.size(), 0);
        check("req_queue_empty", req_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
